// File: rtl/game_pkg.sv
// Shared types and constants for the light-cycle game datapath.
package game_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    FRAME   = 2'b01,
    PLAYER1 = 2'b10,
    PLAYER2 = 2'b11
  } tile;

  localparam int MAP_WIDTH  = 80;
  localparam int MAP_HEIGHT = 60;

  // Heads start an even Manhattan distance apart so a head-on tie is reachable.
  localparam logic [7:0] start_x_1 = 8'd20;
  localparam logic [7:0] start_y_1 = 8'd30;
  localparam logic [7:0] start_x_2 = 8'd60;
  localparam logic [7:0] start_y_2 = 8'd30;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_P1   = 2'b01;
  localparam logic [1:0] SEL_P2   = 2'b11;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b11;
  localparam logic [1:0] WIN_DRAW = 2'b10;

  localparam int TICK_CYCLES_DEFAULT = 2_500_000;

  // Opposite headings differ only in bit 1, so a reversal request keeps the old heading.
  function automatic dir_t turn(dir_t cur, logic [1:0] req);
    logic [1:0] opp;
    opp = cur ^ 2'b10;
    turn = (req == opp) ? cur : dir_t'(req);
  endfunction

  function automatic logic [7:0] next_x(logic [7:0] x, dir_t d);
    case (d)
      RIGHT:   next_x = x + 8'd1;
      LEFT:    next_x = x - 8'd1;
      default: next_x = x;
    endcase
  endfunction

  function automatic logic [7:0] next_y(logic [7:0] y, dir_t d);
    case (d)
      UP:      next_y = y - 8'd1;
      DOWN:    next_y = y + 8'd1;
      default: next_y = y;
    endcase
  endfunction

endpackage

// File: rtl/move_sequencer_tick_gen.sv
// Free-running step pacer: counts 0..CYCLES-1 while enabled, one-cycle tick on the last count.
module tick_gen #(
  parameter int CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/move_sequencer.sv
// Game-step controller: paces steps, looks up target tiles, resolves collisions and
// sequences the per-player map writes.
//
// state     | meaning
// IDLE      | waiting for start, counter held
// WAIT_TICK | counting towards the next step
// LOOK1     | latch headings, compute targets, address P1 target
// LOOK2     | capture P1 target tile, address P2 target
// RESOLVE   | capture P2 target tile, move heads or end the game
// WRITE1    | map write of P1 head
// WRITE2    | map write of P2 head
// OVER      | game ended, frozen until reset
module move_sequencer
  import game_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] dir_1,
  input  logic [1:0] dir_2,
  output logic [7:0] rd_x,
  output logic [7:0] rd_y,
  input  tile        rd_tile,
  output logic [1:0] selected_player,
  output logic [7:0] current_x_1,
  output logic [7:0] current_y_1,
  output logic [7:0] current_x_2,
  output logic [7:0] current_y_2,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    IDLE, WAIT_TICK, LOOK1, LOOK2, RESOLVE, WRITE1, WRITE2, OVER
  } state_t;

  localparam logic [7:0] MAP_W = 8'(MAP_WIDTH);
  localparam logic [7:0] MAP_H = 8'(MAP_HEIGHT);

  state_t     state_q, state_d;
  dir_t       hd1_q, hd1_d, hd2_q, hd2_d;
  logic [7:0] nxt1_x_q, nxt1_x_d, nxt1_y_q, nxt1_y_d;
  logic [7:0] nxt2_x_q, nxt2_x_d, nxt2_y_q, nxt2_y_d;
  tile        t1_q, t1_d;
  logic [7:0] cur_x_1_q, cur_x_1_d, cur_y_1_q, cur_y_1_d;
  logic [7:0] cur_x_2_q, cur_x_2_d, cur_y_2_q, cur_y_2_d;
  logic       game_over_q, game_over_d;
  logic [1:0] winner_q, winner_d;

  logic       tick, tick_en, tick_clr;
  dir_t       look_hd1, look_hd2;
  logic [7:0] look_x1, look_y1, look_x2, look_y2;
  logic       same, oob1, oob2, dead1, dead2;

  tick_gen #(.CYCLES(TICK_CYCLES)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tick_en),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_comb begin
    look_hd1 = turn(hd1_q, dir_1);
    look_hd2 = turn(hd2_q, dir_2);
    look_x1  = next_x(cur_x_1_q, look_hd1);
    look_y1  = next_y(cur_y_1_q, look_hd1);
    look_x2  = next_x(cur_x_2_q, look_hd2);
    look_y2  = next_y(cur_y_2_q, look_hd2);
  end

  // 8-bit wrap from 0 lands at 255, so the >= bound also catches stepping off the low edge.
  always_comb begin
    same  = (nxt1_x_q == nxt2_x_q) && (nxt1_y_q == nxt2_y_q);
    oob1  = (nxt1_x_q >= MAP_W) || (nxt1_y_q >= MAP_H);
    oob2  = (nxt2_x_q >= MAP_W) || (nxt2_y_q >= MAP_H);
    dead1 = (t1_q != EMPTY) || oob1 || same;
    dead2 = (rd_tile != EMPTY) || oob2 || same;
  end

  always_comb begin
    state_d         = state_q;
    hd1_d           = hd1_q;
    hd2_d           = hd2_q;
    nxt1_x_d        = nxt1_x_q;
    nxt1_y_d        = nxt1_y_q;
    nxt2_x_d        = nxt2_x_q;
    nxt2_y_d        = nxt2_y_q;
    t1_d            = t1_q;
    cur_x_1_d       = cur_x_1_q;
    cur_y_1_d       = cur_y_1_q;
    cur_x_2_d       = cur_x_2_q;
    cur_y_2_d       = cur_y_2_q;
    game_over_d     = game_over_q;
    winner_d        = winner_q;
    selected_player = SEL_NONE;
    rd_x            = 8'd0;
    rd_y            = 8'd0;
    tick_en         = (state_q != IDLE) && (state_q != OVER);
    tick_clr        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          tick_clr = 1'b1;
          state_d  = WAIT_TICK;
        end
      end
      WAIT_TICK: begin
        if (tick) state_d = LOOK1;
      end
      LOOK1: begin
        hd1_d    = look_hd1;
        hd2_d    = look_hd2;
        nxt1_x_d = look_x1;
        nxt1_y_d = look_y1;
        nxt2_x_d = look_x2;
        nxt2_y_d = look_y2;
        rd_x     = look_x1;
        rd_y     = look_y1;
        state_d  = LOOK2;
      end
      LOOK2: begin
        t1_d    = rd_tile;
        rd_x    = nxt2_x_q;
        rd_y    = nxt2_y_q;
        state_d = RESOLVE;
      end
      RESOLVE: begin
        if (!dead1 && !dead2) begin
          cur_x_1_d = nxt1_x_q;
          cur_y_1_d = nxt1_y_q;
          cur_x_2_d = nxt2_x_q;
          cur_y_2_d = nxt2_y_q;
          state_d   = WRITE1;
        end else begin
          game_over_d = 1'b1;
          if (dead1 && dead2) winner_d = WIN_DRAW;
          else if (dead1)     winner_d = WIN_P2;
          else                winner_d = WIN_P1;
          state_d = OVER;
        end
      end
      WRITE1: begin
        selected_player = SEL_P1;
        state_d         = WRITE2;
      end
      WRITE2: begin
        selected_player = SEL_P2;
        state_d         = WAIT_TICK;
      end
      OVER: begin
        state_d = OVER;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hd1_q       <= RIGHT;
      hd2_q       <= LEFT;
      nxt1_x_q    <= 8'd0;
      nxt1_y_q    <= 8'd0;
      nxt2_x_q    <= 8'd0;
      nxt2_y_q    <= 8'd0;
      t1_q        <= EMPTY;
      cur_x_1_q   <= start_x_1;
      cur_y_1_q   <= start_y_1;
      cur_x_2_q   <= start_x_2;
      cur_y_2_q   <= start_y_2;
      game_over_q <= 1'b0;
      winner_q    <= WIN_NONE;
    end else begin
      state_q     <= state_d;
      hd1_q       <= hd1_d;
      hd2_q       <= hd2_d;
      nxt1_x_q    <= nxt1_x_d;
      nxt1_y_q    <= nxt1_y_d;
      nxt2_x_q    <= nxt2_x_d;
      nxt2_y_q    <= nxt2_y_d;
      t1_q        <= t1_d;
      cur_x_1_q   <= cur_x_1_d;
      cur_y_1_q   <= cur_y_1_d;
      cur_x_2_q   <= cur_x_2_d;
      cur_y_2_q   <= cur_y_2_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign current_x_1 = cur_x_1_q;
  assign current_y_1 = cur_y_1_q;
  assign current_x_2 = cur_x_2_q;
  assign current_y_2 = cur_y_2_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;

endmodule

// File: doc/move_sequencer.md
# move_sequencer

Game-step controller for the light-cycle map datapath. It paces the game with a tick counter and turns player direction inputs into head moves. Each step it looks up the target tiles, resolves collisions, and then writes the new heads into the map by driving `selected_player` and the `current_x/y` coordinates for one cycle per player. It sits between the keyboard/direction logic and the map register array, and also feeds the game-over and winner status to the VGA overlay.

## Interface

Parameters:
- `TICK_CYCLES`, default 2_500_000: clock cycles per game step. Must be ≥ 8.

Ports:
- `clk`  in  1  system clock. One clock domain only.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse that starts the game. Honoured only in IDLE.
- `dir_1`, `dir_2`  in  2 each  requested heading: 00 up, 01 right, 10 down, 11 left.
- `rd_x`, `rd_y`  out  8 each  map lookup address.
- `rd_tile`  in  `tile`  map contents at the address driven in the previous cycle (one-cycle read latency).
- `selected_player`  out  2  map write select: 00 none, 01 write PLAYER1, 11 write PLAYER2.
- `current_x_1`, `current_y_1`, `current_x_2`, `current_y_2`  out  8 each  head positions.
- `game_over`  out  1  high once the game has ended; stays high until reset.
- `winner`  out  2  00 none, 01 P1 wins, 11 P2 wins, 10 draw.

## Operation

- Reset values:
  - State IDLE.
  - `selected_player`=00, `rd_x`/`rd_y`=0, `game_over`=0, `winner`=00.
  - Heads at package constants (`start_x_1`,`start_y_1`) and (`start_x_2`,`start_y_2`).
  - Heading P1=right, P2=left. Tick counter=0.
- States:
  - IDLE: on `start`, clear the counter and go to WAIT_TICK.
  - WAIT_TICK: on tick, go to LOOK1.
  - LOOK1:
    - Sample `dir_1` and `dir_2`. A request opposite to the current heading is ignored; otherwise the heading is updated.
    - Compute `nxt1` and `nxt2` (x or y ±1, 8-bit).
    - Drive `rd_x`/`rd_y` = `nxt1`.
  - LOOK2: capture `rd_tile` as `t1`; drive `rd_x`/`rd_y` = `nxt2`.
  - RESOLVE: capture `t2` and decide.
    - `dead1` = (`t1`≠EMPTY) or `nxt1` out of range (x ≥ MAP_WIDTH or y ≥ MAP_HEIGHT) or (`nxt1`==`nxt2`). `dead2` is symmetric.
    - Neither dead: load `current_*` ← `nxt*`, go to WRITE1.
    - Otherwise: set `game_over`=1 and go to OVER, with `winner` = 01 if only P2 died, 11 if only P1 died, 10 if both died. Positions are not updated.
  - WRITE1: `selected_player`=01 for exactly one cycle, then WRITE2.
  - WRITE2: `selected_player`=11 for exactly one cycle, then WAIT_TICK.
  - OVER: terminal. `selected_player`=00; `start` is ignored; only `rst_n` leaves it.
- Out-of-range targets, including 8-bit wrap from 0 to 255, count as collisions. The `rd_tile` value read for such an address is don't-care.
- `selected_player` is 00 in every state except WRITE1 and WRITE2.
- `start` asserted outside IDLE has no effect.

## Timing

- Tick counter:
  - Runs in every state except IDLE and OVER.
  - Counts 0..TICK_CYCLES-1 and wraps.
  - The tick is one cycle long, at count TICK_CYCLES-1.
  - Step period is exactly TICK_CYCLES cycles.
- Step sequence from tick to return to WAIT_TICK: LOOK1, LOOK2, RESOLVE, WRITE1, WRITE2, i.e. 5 cycles. The next tick therefore always finds the FSM in WAIT_TICK.
- Head registers change on the clock edge that enters WRITE1. They are stable through WRITE1 and WRITE2, so the map writes the new coordinates on the edges ending WRITE1 (P1) and WRITE2 (P2).
- The first tick occurs TICK_CYCLES cycles after `start` is accepted.
- `rst_n` assertion at any point clears all state asynchronously, including mid-step and in OVER. Deassertion is synchronised externally.
- A direction change is applied only if present in the LOOK1 cycle.

## Structure

- `game_pkg`:
  - `dir_t` enum (UP/RIGHT/DOWN/LEFT = 0..3).
  - Player-select codes SEL_NONE=00, SEL_P1=01, SEL_P2=11.
  - Winner codes.
  - Default TICK_CYCLES.
  - The existing `tile`, MAP_WIDTH, MAP_HEIGHT and start constants are reused.
- FSM state enum is local to the module.
- One sub-module, `tick_gen`: parameterised counter with enable and synchronous clear, emitting the one-cycle tick.

## Test plan

All scenarios run with TICK_CYCLES=8 and a bench map model with 1-cycle read latency.
- Reset, then `start`, no turns:
  - After the first tick, `selected_player` reads 00,00,00,01,11.
  - `current_x_1` = `start_x_1`+1; `current_x_2` = `start_x_2`−1.
  - The second step follows exactly 8 cycles later.
- `dir_1`=00 held through LOOK1 → `current_y_1` decrements by 1 and x is unchanged. `dir_1`=11 (reverse of right) → ignored, and x increments.
- P1 driven left until x reaches 1; the next target is the FRAME column at x=0 → `game_over`=1, `winner`=11, no further `selected_player` pulses, positions frozen.
- Heads placed so both target the same empty tile → `winner`=10; P1 target on a PLAYER2 trail with P2 free → `winner`=11.
- `rst_n` pulsed low during WRITE1 → outputs immediately show reset values; `start` asserted in OVER → no change.
